// File: rtl/k12a_fetch_unit.sv
// Two-byte instruction fetch sequencer wrapped around the PC register.
// Optional `K12A_FETCH_WAIT_EN adds a mem_ready stall input for slow program memory.
module k12a_fetch_unit #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic [15:0] pc,
  inout  wire  [15:0] addr_bus,
  output logic        pc_load_n,
  output logic        pc_store,
  output logic        mem_rd_n,
  input  logic [7:0]  mem_data,
`ifdef K12A_FETCH_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic [15:0] inst,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        jump_req,
  input  logic [15:0] jump_target,
  output logic        jump_ack
);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, INC1, FETCH_B, INC2, HOLD, JUMP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  shadow;
  logic [15:0] jump_tgt_q;
  logic        bus_drv;
  logic [15:0] bus_val;
  logic        mem_go;

`ifdef K12A_FETCH_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Only INC1/INC2/JUMP drive the bus; the PC owns it while pc_load_n is low.
  assign addr_bus = bus_drv ? bus_val : 16'hzzzz;

  always_comb begin
    state_nxt  = state;
    pc_load_n  = 1'b1;
    pc_store   = 1'b0;
    mem_rd_n   = 1'b1;
    inst_valid = 1'b0;
    jump_ack   = 1'b0;
    bus_drv    = 1'b0;
    bus_val    = pc + 16'd1;
    case (state)
      IDLE: begin
        if (jump_req)      state_nxt = JUMP;
        else if (fetch_en) state_nxt = FETCH_A;
      end
      FETCH_A: begin
        pc_load_n = 1'b0;
        mem_rd_n  = 1'b0;
        if (mem_go) state_nxt = INC1;
      end
      INC1: begin
        bus_drv   = 1'b1;
        pc_store  = 1'b1;
        state_nxt = FETCH_B;
      end
      FETCH_B: begin
        pc_load_n = 1'b0;
        mem_rd_n  = 1'b0;
        if (mem_go) state_nxt = INC2;
      end
      INC2: begin
        bus_drv   = 1'b1;
        pc_store  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (jump_req)                  state_nxt = JUMP;
        else if (inst_ack && fetch_en) state_nxt = FETCH_A;
        else if (inst_ack)             state_nxt = IDLE;
      end
      JUMP: begin
        bus_drv   = 1'b1;
        bus_val   = jump_tgt_q;
        pc_store  = 1'b1;
        jump_ack  = 1'b1;
        state_nxt = fetch_en ? FETCH_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shadow     <= 8'h00;
      inst       <= 16'h0000;
      jump_tgt_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == FETCH_A && mem_go) shadow <= mem_data;
      // Both halves land together so inst never shows a half-updated word.
      if (state == FETCH_B && mem_go)
        inst <= HI_FIRST ? {shadow, mem_data} : {mem_data, shadow};
      if (state_nxt == JUMP && state != JUMP) jump_tgt_q <= jump_target;
    end
  end

endmodule

// File: tb/tb_k12a_fetch_unit.sv
// Bench for k12a_fetch_unit: two instances (HI_FIRST=1 and 0) each with a PC register and shared program memory.
module tb_k12a_fetch_unit;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, inst_ack, jump_req;
  logic [15:0] jump_target;
  logic        pc_wr_en;
  logic [15:0] pc_wr_val;
  logic        mem_ready;
  logic        mdl_on;
  logic [7:0]  mem [0:65535];

  logic [NI-1:0][15:0] inst_o, pc_o, bus_o;
  logic [NI-1:0]       vld_o, jack_o, pcl_o, pcs_o, rd_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_a [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_i
    wire  [15:0] bus;
    wire  [7:0]  md;
    logic [15:0] pc_q;
    logic [15:0] inst_w;
    logic        pcl, pcs, rd, vld, jack;

    assign bus = pcl ? 16'hzzzz : pc_q;
    assign md  = rd ? 8'h00 : mem[bus];

    always @(posedge clk)
      if (pc_wr_en) pc_q <= pc_wr_val;
      else if (pcs) pc_q <= bus;

    k12a_fetch_unit #(.HI_FIRST(g == 0)) u_dut (
      .cpu_clock(clk), .reset_n(reset_n), .fetch_en(fetch_en), .pc(pc_q),
      .addr_bus(bus), .pc_load_n(pcl), .pc_store(pcs), .mem_rd_n(rd),
      .mem_data(md),
`ifdef K12A_FETCH_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .inst(inst_w), .inst_valid(vld), .inst_ack(inst_ack),
      .jump_req(jump_req), .jump_target(jump_target), .jump_ack(jack)
    );

    assign inst_o[g] = inst_w;
    assign pc_o[g]   = pc_q;
    assign bus_o[g]  = bus;
    assign vld_o[g]  = vld;
    assign jack_o[g] = jack;
    assign pcl_o[g]  = pcl;
    assign pcs_o[g]  = pcs;
    assign rd_o[g]   = rd;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction at byte address a as the decoder should see it.
  function automatic logic [15:0] asm_inst(input int g, input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return (g == 0) ? {mem[a], mem[a1]} : {mem[a1], mem[a]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_wr_en  = 1'b1;
    pc_wr_val = v;
    tick();
    pc_wr_en  = 1'b0;
    mdl_on    = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!vld_o[0] && n < max);
    chk("wait_valid", {15'd0, vld_o[0]}, 16'd1);
  endtask

  int n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset_n = 1'b0; fetch_en = 1'b0; inst_ack = 1'b0; jump_req = 1'b0;
    jump_target = 16'h0000; pc_wr_en = 1'b0; pc_wr_val = 16'h0000;
    mem_ready = 1'b1; mdl_on = 1'b0;
    exp_a[0] = 16'h0000; exp_a[1] = 16'h0000;

    // Per-cycle model check: inst/PC follow the expected fetch address, bus ownership stays exclusive.
    fork
      forever begin
        @(negedge clk);
        if (reset_n && mdl_on) begin
          for (int g = 0; g < NI; g++) begin
            if (vld_o[g]) begin
              chk("mdl_inst", inst_o[g], asm_inst(g, exp_a[g]));
              chk("mdl_pc_after_fetch", pc_o[g], exp_a[g] + 16'd2);
            end
            if (pcs_o[g]) begin
              chk("mdl_bus_excl", {15'd0, pcl_o[g]}, 16'd1);
              chk("mdl_bus_val", bus_o[g], jack_o[g] ? jump_target : pc_o[g] + 16'd1);
            end
            if (!rd_o[g]) begin
              chk("mdl_rd_pcl", {15'd0, pcl_o[g]}, 16'd0);
              chk("mdl_rd_addr", bus_o[g], pc_o[g]);
            end
            if (vld_o[g] && (inst_ack || jump_req)) exp_a[g] = exp_a[g] + 16'd2;
            if (jack_o[g]) exp_a[g] = jump_target;
            if (pc_wr_en) exp_a[g] = pc_wr_val;
          end
        end
      end
    join_none

    // Reset values
    #3;
    chk("rst_valid", {14'd0, vld_o}, 16'd0);
    chk("rst_inst0", inst_o[0], 16'h0000);
    chk("rst_jack", {14'd0, jack_o}, 16'd0);
    chk("rst_pcl", {14'd0, pcl_o}, 16'd3);
    chk("rst_pcs", {14'd0, pcs_o}, 16'd0);
    chk("rst_rd", {14'd0, rd_o}, 16'd3);
    #1 reset_n = 1'b1;
    tick();

    // Basic fetch, then back-to-back
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
    mem[16'h0002] = 8'h56; mem[16'h0003] = 8'h78;
    set_pc(16'h0000);
    fetch_en = 1'b1; inst_ack = 1'b1;
    wait_valid(20, n);
    chk("lat_first", 16'(n), 16'd5);
    chk("inst_hi_first", inst_o[0], 16'h1234);
    chk("inst_lo_first", inst_o[1], 16'h3412);
    chk("pc_after_1", pc_o[0], 16'h0002);
    wait_valid(20, n);
    chk("lat_b2b", 16'(n), 16'd5);
    chk("inst2_hi", inst_o[0], 16'h5678);
    chk("inst2_lo", inst_o[1], 16'h7856);
    fetch_en = 1'b0;
    tick();
    chk("idle_valid", {14'd0, vld_o}, 16'd0);
    tick();
    chk("idle_pc", pc_o[0], 16'h0004);

    // PC wrap
    mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
    set_pc(16'hFFFF);
    fetch_en = 1'b1;
    wait_valid(20, n);
    chk("wrap_inst_hi", inst_o[0], 16'hABCD);
    chk("wrap_inst_lo", inst_o[1], 16'hCDAB);
    chk("wrap_pc", pc_o[0], 16'h0001);
    fetch_en = 1'b0;
    tick();

    // Hold without ack, then jump discards the held instruction
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h4000] = 8'h9A; mem[16'h4001] = 8'hBC;
    set_pc(16'h0100);
    inst_ack = 1'b0; fetch_en = 1'b1;
    wait_valid(20, n);
    tick(); tick();
    chk("hold_valid", {15'd0, vld_o[0]}, 16'd1);
    chk("hold_inst", inst_o[0], 16'h1122);
    jump_req = 1'b1; jump_target = 16'h4000;
    tick();
    chk("jmp_valid_drop", {14'd0, vld_o}, 16'd0);
    chk("jmp_ack", {15'd0, jack_o[0]}, 16'd1);
    chk("jmp_bus", bus_o[0], 16'h4000);
    jump_req = 1'b0; inst_ack = 1'b1;
    tick();
    chk("jmp_ack_pulse", {15'd0, jack_o[0]}, 16'd0);
    chk("jmp_pc", pc_o[0], 16'h4000);
    wait_valid(20, n);
    chk("jmp_lat", 16'(n), 16'd4);
    chk("jmp_inst", inst_o[0], 16'h9ABC);
    chk("jmp_pc2", pc_o[0], 16'h4002);
    fetch_en = 1'b0;
    tick();

    // Jump requested mid-fetch waits for HOLD
    mem[16'h0200] = 8'hDE; mem[16'h0201] = 8'hAD;
    set_pc(16'h0200);
    fetch_en = 1'b1;
    tick(); tick(); tick();
    chk("fb_rd", {15'd0, rd_o[0]}, 16'd0);
    jump_req = 1'b1; jump_target = 16'h0300;
    tick();
    chk("fb_no_ack", {15'd0, jack_o[0]}, 16'd0);
    tick();
    chk("fb_hold_valid", {15'd0, vld_o[0]}, 16'd1);
    chk("fb_inst_hi", inst_o[0], 16'hDEAD);
    chk("fb_inst_lo", inst_o[1], 16'hADDE);
    fetch_en = 1'b0;
    tick();
    chk("fb_jack", {15'd0, jack_o[0]}, 16'd1);
    jump_req = 1'b0;
    tick();
    chk("fb_pc", pc_o[0], 16'h0300);
    chk("fb_idle", {14'd0, vld_o}, 16'd0);

    // Asynchronous reset during INC1
    set_pc(16'h0500);
    fetch_en = 1'b1;
    tick(); tick();
    chk("inc1_store", {15'd0, pcs_o[0]}, 16'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_store", {14'd0, pcs_o}, 16'd0);
    chk("mid_rst_pcl", {14'd0, pcl_o}, 16'd3);
    chk("mid_rst_rd", {14'd0, rd_o}, 16'd3);
    chk("mid_rst_inst0", inst_o[0], 16'h0000);
    chk("mid_rst_inst1", inst_o[1], 16'h0000);
    chk("mid_rst_valid", {14'd0, vld_o}, 16'd0);
    chk("mid_rst_bus_rel", {15'd0, (bus_o[0] === 16'hzzzz) || (bus_o[0] === 16'h0000)}, 16'd1);
    fetch_en = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", {15'd0, pcs_o[0]}, 16'd0);
    chk("post_rst_pc", pc_o[0], 16'h0500);

`ifdef K12A_FETCH_WAIT_EN
    // Three wait cycles in FETCH_A stretch latency by exactly three
    mem[16'h0600] = 8'h5A; mem[16'h0601] = 8'hA5;
    set_pc(16'h0600);
    mem_ready = 1'b0; fetch_en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 4) mem_ready = 1'b1;
    end while (!vld_o[0] && n < 30);
    chk("wait_valid_ws", {15'd0, vld_o[0]}, 16'd1);
    chk("wait_lat", 16'(n), 16'd8);
    chk("wait_inst", inst_o[0], 16'h5AA5);
    fetch_en = 1'b0;
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/k12a_fetch_unit.md
Name: k12a_fetch_unit

Overview:
Instruction fetch sequencer that sits directly upstream of and around the PC register.
- Each 16-bit instruction is read as two bytes from 8-bit asynchronous program memory.
- The PC register is told when to drive the 16-bit address bus and when to capture it; this block drives pc+1 or a jump target onto the bus for the PC to load.
- Assembled instructions are handed to the decoder through a valid/ack handshake.

Parameters:
HI_FIRST, 1, 1: first byte fetched is inst[15:8]; 0: first byte is inst[7:0]

Ports:
cpu_clock  input  1  CPU clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
fetch_en  input  1  run enable; level-sensitive
pc  input  16  current PC register value
addr_bus  inout  16  shared address bus; driven by this block only in INC1/INC2/JUMP, else 16'hzzzz
pc_load_n  output  1  active-low; PC drives addr_bus
pc_store  output  1  PC captures addr_bus at next edge
mem_rd_n  output  1  active-low program memory read strobe
mem_data  input  8  program memory read data, valid combinationally during mem_rd_n=0
inst  output  16  assembled instruction
inst_valid  output  1  inst holds a complete instruction
inst_ack  input  1  decoder consumes inst (with inst_valid)
jump_req  input  1  request to load jump_target into PC; held until jump_ack
jump_target  input  16  jump destination
jump_ack  output  1  one-cycle pulse, jump accepted

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, inst=0, inst_valid=0, jump_ack=0, pc_load_n=1, pc_store=0, mem_rd_n=1, addr_bus released. Applies mid-fetch; any partial byte is discarded.
- States and outputs (outputs decoded from state, registered state):
  - IDLE: all strobes inactive.
  - FETCH_A: pc_load_n=0, mem_rd_n=0; first byte latched from mem_data at exit edge.
  - INC1: addr_bus=pc+1 (16-bit, wraps FFFF→0000), pc_store=1.
  - FETCH_B: as FETCH_A; second byte latched.
  - INC2: as INC1.
  - HOLD: inst_valid=1.
  - JUMP: addr_bus=latched jump_target, pc_store=1, jump_ack=1.
- Transitions:
  - IDLE: jump_req→JUMP; else fetch_en→FETCH_A; else stay.
  - FETCH_A→INC1→FETCH_B→INC2→HOLD, unconditional. jump_req and fetch_en are ignored in these states.
  - HOLD:
    - jump_req→JUMP; the instruction is consumed if inst_ack=1, otherwise discarded (inst_valid drops).
    - Else inst_ack and fetch_en→FETCH_A.
    - Else inst_ack→IDLE.
    - Else stay; inst stable.
  - JUMP→FETCH_A if fetch_en, else IDLE.
- jump_target is sampled at the edge entering JUMP. jump_req must drop the cycle after jump_ack.
- Latency: from fetch_en high in IDLE, inst_valid rises at the 5th rising edge. With back-to-back acks, one instruction every 5 cycles.
- Byte placement: HI_FIRST=1 puts the FETCH_A byte in inst[15:8] and the FETCH_B byte in inst[7:0]; HI_FIRST=0 swaps them. inst updates only on the FETCH_B exit edge (both halves atomically from a shadow byte).
- Bus rule: pc_load_n=0 and addr-bus drive are never both active; at most one driver exists in any state.

Optional Feature:
K12A_FETCH_WAIT_EN
- Defined: adds input mem_ready (1 bit). In FETCH_A/FETCH_B, mem_ready=0 holds the state with strobes held and no byte latched. The state advances on the first edge with mem_ready=1.
- Undefined: no mem_ready port; memory is assumed single-cycle.

Test Plan:
- Reset, fetch_en=1, PC=0000, mem[0]=12, mem[1]=34, ack held 1 → inst_valid at edge 5, inst=1234, PC=0002.
- HI_FIRST=0, same memory → inst=3412.
- PC=FFFF, mem[FFFF]=AB, mem[0000]=CD → inst=ABCD, PC wraps to 0001.
- In HOLD with ack=0, assert jump_req, jump_target=4000 → inst_valid drops, one-cycle jump_ack, PC=4000, next fetch reads 4000/4001.
- jump_req asserted during FETCH_B → ignored until HOLD, then accepted; the fetched instruction is not corrupted.
- reset_n pulsed low in INC1 → all outputs at reset values immediately, addr_bus=zzzz. With K12A_FETCH_WAIT_EN, mem_ready=0 for 3 cycles in FETCH_A → inst_valid delayed by exactly 3 cycles.
